// File: rtl/reservation_station_n_pkg.sv
// Shared types for the reservation station.
// - Entry state enum (FREE/WAIT/READY/RUNNING).
// - Entry record: a pending operand keeps its producer tag in the low bits
//   of the operand field; once the operand is captured, the field holds its value.
// - is_mem_op(): routes an opcode to the memory unit instead of the ALU.
package reservation_station_n_pkg;
  localparam int RS_DEPTH      = 8;
  localparam int RS_TAG_W      = 3;
  localparam int RS_DATA_W     = 16;
  localparam int RS_OP_W       = 4;
  localparam int RS_REG_W      = 4;
  localparam int RS_MEM_OP_BIT = 3;

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_READY   = 2'd2,
    ST_RUNNING = 2'd3
  } ent_state_e;

  typedef struct packed {
    ent_state_e             state;
    logic [RS_OP_W-1:0]     op;
    logic [RS_REG_W-1:0]    dest;
    logic                   b_pend;
    logic [RS_DATA_W-1:0]   b;      // tag while b_pend, value otherwise
    logic                   c_pend;
    logic [RS_DATA_W-1:0]   c;      // tag while c_pend, value otherwise
  } rs_entry_t;

  // Mask test keeps every opcode bit referenced.
  function automatic logic is_mem_op(input logic [RS_OP_W-1:0] op);
    return |(op & (RS_OP_W'(1) << RS_MEM_OP_BIT));
  endfunction
endpackage

// File: rtl/reservation_station_n_if.sv
// Issue / CDB / dispatch bundle of the reservation station.
// - slave  : the reservation station's view (drives issue_ready, dispatch, occupancy).
// - master : the surrounding pipeline's view (drives issue, CDB, unit readies).
interface reservation_station_n_if import reservation_station_n_pkg::*; #(
  parameter int TAG_W  = RS_TAG_W,
  parameter int DATA_W = RS_DATA_W,
  parameter int OP_W   = RS_OP_W,
  parameter int REG_W  = RS_REG_W
);
  // issue
  logic              issue_valid;
  logic              issue_ready;
  logic [TAG_W-1:0]  issue_tag;
  logic [OP_W-1:0]   issue_op;
  logic [REG_W-1:0]  issue_dest;
  logic              issue_b_pend;
  logic [TAG_W-1:0]  issue_b_tag;
  logic [DATA_W-1:0] issue_b_val;
  logic              issue_c_pend;
  logic [TAG_W-1:0]  issue_c_tag;
  logic [DATA_W-1:0] issue_c_val;
  // common data bus
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  // dispatch
  logic              alu_valid;
  logic              alu_ready;
  logic              mem_valid;
  logic              mem_ready;
  logic [TAG_W-1:0]  out_tag;
  logic [OP_W-1:0]   out_op;
  logic [REG_W-1:0]  out_dest;
  logic [DATA_W-1:0] out_b;
  logic [DATA_W-1:0] out_c;
  logic [TAG_W:0]    occupancy;

  modport slave (
    input  issue_valid, issue_op, issue_dest,
           issue_b_pend, issue_b_tag, issue_b_val,
           issue_c_pend, issue_c_tag, issue_c_val,
           cdb_valid, cdb_tag, cdb_data, alu_ready, mem_ready,
    output issue_ready, issue_tag, alu_valid, mem_valid,
           out_tag, out_op, out_dest, out_b, out_c, occupancy
  );

  modport master (
    output issue_valid, issue_op, issue_dest,
           issue_b_pend, issue_b_tag, issue_b_val,
           issue_c_pend, issue_c_tag, issue_c_val,
           cdb_valid, cdb_tag, cdb_data, alu_ready, mem_ready,
    input  issue_ready, issue_tag, alu_valid, mem_valid,
           out_tag, out_op, out_dest, out_b, out_c, occupancy
  );
endinterface

// File: rtl/reservation_station_n_age_matrix.sv
// rs_age_matrix: relative age tracker for DEPTH slots.
// - r_older[i][j] = 1 means slot i was allocated before slot j.
// Ports:
//   clock    in  clock
//   i_clr    in  synchronous clear (reset / flush)
//   i_alloc  in  one-hot slot being allocated (becomes youngest)
//   i_free   in  one-hot slot being released
//   i_req    in  request vector (READY slots)
//   o_grant  out one-hot oldest requester
module rs_age_matrix #(
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             i_clr,
  input  logic [DEPTH-1:0] i_alloc,
  input  logic [DEPTH-1:0] i_free,
  input  logic [DEPTH-1:0] i_req,
  output logic [DEPTH-1:0] o_grant
);
  logic [DEPTH-1:0][DEPTH-1:0] r_older;

  always_ff @(posedge clock) begin
    if (i_clr) begin
      r_older <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (i == j)                      r_older[i][j] <= 1'b0;
          else if (i_alloc[j])             r_older[i][j] <= 1'b1; // everyone predates the new slot
          else if (i_alloc[i])             r_older[i][j] <= 1'b0;
          else if (i_free[i] || i_free[j]) r_older[i][j] <= 1'b0;
        end
      end
    end
  end

  // A requester wins when no other requester is older than it.
  always_comb begin
    o_grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_grant[i] = i_req[i];
      for (int j = 0; j < DEPTH; j++)
        if (j != i && i_req[j] && r_older[j][i]) o_grant[i] = 1'b0;
    end
  end
endmodule

// File: rtl/reservation_station_n.sv
// reservation_station_n: Tomasulo reservation station, DEPTH entries.
// - The entry index is the op's result tag.
// - Entries wait for operands by snooping the CDB.
// - The oldest READY entry is dispatched over valid/ready to the ALU or the memory unit.
// - An entry frees when its own tag appears on the CDB while RUNNING.
// Ports:
//   clock   in  rising-edge clock
//   resetn  in  synchronous active-low reset; all outputs forced to 0 while low
//   flush   in  synchronous clear of every entry; overrides same-cycle issue/dispatch
//   bus     slave modport of reservation_station_n_if (issue, CDB, dispatch, occupancy)
module reservation_station_n import reservation_station_n_pkg::*; #(
  parameter int DEPTH  = RS_DEPTH,
  parameter int TAG_W  = RS_TAG_W,
  parameter int DATA_W = RS_DATA_W
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   flush,
  reservation_station_n_if.slave bus
);
  rs_entry_t          r_ent [DEPTH];
  rs_entry_t          w_nxt [DEPTH];
  rs_entry_t          w_new;
  logic               r_hold;
  logic [TAG_W-1:0]   r_hold_idx;

  logic [DEPTH-1:0]   w_req, w_grant, w_sel, w_free, w_alloc_oh;
  logic [TAG_W-1:0]   w_alloc_idx, w_sel_idx;
  logic               w_free_any, w_any, w_sel_mem, w_issue, w_hs, w_clr;
  logic [TAG_W:0]     w_occ;

  // Slot scan on registered state only: lowest FREE slot, occupancy, READY set, CDB free.
  always_comb begin
    w_alloc_idx = '0;
    w_free_any  = 1'b0;
    w_occ       = '0;
    w_req       = '0;
    w_free      = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (r_ent[i].state == ST_FREE) begin
        w_alloc_idx = TAG_W'(i);
        w_free_any  = 1'b1;
      end else begin
        w_occ = w_occ + (TAG_W+1)'(1);
      end
      w_req[i]  = (r_ent[i].state == ST_READY);
      w_free[i] = bus.cdb_valid && (r_ent[i].state == ST_RUNNING) &&
                  (bus.cdb_tag == TAG_W'(i));
    end
  end

  assign w_issue    = bus.issue_valid && bus.issue_ready;
  assign w_alloc_oh = w_issue ? (DEPTH'(1) << w_alloc_idx) : '0;
  assign w_clr      = !resetn || flush;

  rs_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clock   (clock),
    .i_clr   (w_clr),
    .i_alloc (w_alloc_oh),
    .i_free  (w_free),
    .i_req   (w_req),
    .o_grant (w_grant)
  );

  // A presented entry stays selected until accepted, even if an older
  // entry becomes READY meanwhile; it cannot leave READY before handshake.
  always_comb begin
    w_sel     = r_hold ? (DEPTH'(1) << r_hold_idx) : w_grant;
    w_any     = |w_sel;
    w_sel_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (w_sel[i]) w_sel_idx = TAG_W'(i);
    w_sel_mem = is_mem_op(r_ent[w_sel_idx].op);
  end

  assign w_hs = (bus.alu_valid && bus.alu_ready) || (bus.mem_valid && bus.mem_ready);

  // New entry, with same-cycle CDB bypass on pending operands.
  always_comb begin
    w_new        = '0;
    w_new.op     = bus.issue_op;
    w_new.dest   = bus.issue_dest;
    w_new.b_pend = bus.issue_b_pend;
    w_new.b      = bus.issue_b_pend ? DATA_W'(bus.issue_b_tag) : bus.issue_b_val;
    w_new.c_pend = bus.issue_c_pend;
    w_new.c      = bus.issue_c_pend ? DATA_W'(bus.issue_c_tag) : bus.issue_c_val;
    if (bus.issue_b_pend && bus.cdb_valid && bus.issue_b_tag == bus.cdb_tag) begin
      w_new.b_pend = 1'b0;
      w_new.b      = bus.cdb_data;
    end
    if (bus.issue_c_pend && bus.cdb_valid && bus.issue_c_tag == bus.cdb_tag) begin
      w_new.c_pend = 1'b0;
      w_new.c      = bus.cdb_data;
    end
    w_new.state = (w_new.b_pend || w_new.c_pend) ? ST_WAIT : ST_READY;
  end

  // Per-entry state transitions.
  always_comb begin
    w_nxt = r_ent;
    for (int i = 0; i < DEPTH; i++) begin
      case (r_ent[i].state)
        ST_WAIT: begin
          if (bus.cdb_valid && r_ent[i].b_pend && r_ent[i].b[TAG_W-1:0] == bus.cdb_tag) begin
            w_nxt[i].b      = bus.cdb_data;
            w_nxt[i].b_pend = 1'b0;
          end
          if (bus.cdb_valid && r_ent[i].c_pend && r_ent[i].c[TAG_W-1:0] == bus.cdb_tag) begin
            w_nxt[i].c      = bus.cdb_data;
            w_nxt[i].c_pend = 1'b0;
          end
          if (!w_nxt[i].b_pend && !w_nxt[i].c_pend) w_nxt[i].state = ST_READY;
        end
        ST_READY:   if (w_hs && w_sel[i]) w_nxt[i].state = ST_RUNNING;
        ST_RUNNING: if (w_free[i])        w_nxt[i].state = ST_FREE;
        default: ;
      endcase
    end
    // Issue only targets a FREE slot, so it never collides with the updates above.
    if (w_issue) w_nxt[w_alloc_idx] = w_new;
  end

  always_ff @(posedge clock) begin
    if (w_clr) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_hold     <= 1'b0;
      r_hold_idx <= '0;
    end else begin
      r_ent      <= w_nxt;
      r_hold     <= w_any && !w_hs;
      r_hold_idx <= w_sel_idx;
    end
  end

  assign bus.issue_ready = resetn && w_free_any;
  assign bus.issue_tag   = resetn ? w_alloc_idx : '0;
  assign bus.occupancy   = resetn ? w_occ : '0;
  assign bus.alu_valid   = resetn && w_any && !w_sel_mem;
  assign bus.mem_valid   = resetn && w_any &&  w_sel_mem;
  assign bus.out_tag     = resetn ? w_sel_idx : '0;
  assign bus.out_op      = resetn ? r_ent[w_sel_idx].op   : '0;
  assign bus.out_dest    = resetn ? r_ent[w_sel_idx].dest : '0;
  assign bus.out_b       = resetn ? r_ent[w_sel_idx].b    : '0;
  assign bus.out_c       = resetn ? r_ent[w_sel_idx].c    : '0;
endmodule

// File: tb/tb_reservation_station_n.sv
// Directed bench for reservation_station_n (DEPTH=8, TAG_W=3, DATA_W=16).
module tb_reservation_station_n;
  logic clock = 1'b0;
  logic resetn;
  logic flush;
  int   n_cmp = 0;
  int   n_bad = 0;

  reservation_station_n_if #(.TAG_W(3), .DATA_W(16), .OP_W(4), .REG_W(4)) bus ();

  reservation_station_n #(.DEPTH(8), .TAG_W(3), .DATA_W(16)) dut (
    .clock  (clock),
    .resetn (resetn),
    .flush  (flush),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic idle_inputs();
    bus.issue_valid = 0; bus.issue_op = '0; bus.issue_dest = '0;
    bus.issue_b_pend = 0; bus.issue_b_tag = '0; bus.issue_b_val = '0;
    bus.issue_c_pend = 0; bus.issue_c_tag = '0; bus.issue_c_val = '0;
    bus.cdb_valid = 0; bus.cdb_tag = '0; bus.cdb_data = '0;
    bus.alu_ready = 0; bus.mem_ready = 0; flush = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 0; tick(); resetn = 1;
  endtask

  task automatic set_issue(input logic [3:0] op, input logic [3:0] dest,
                           input logic bp, input logic [2:0] bt, input logic [15:0] bv,
                           input logic cp, input logic [2:0] ct, input logic [15:0] cv);
    bus.issue_op = op; bus.issue_dest = dest;
    bus.issue_b_pend = bp; bus.issue_b_tag = bt; bus.issue_b_val = bv;
    bus.issue_c_pend = cp; bus.issue_c_tag = ct; bus.issue_c_val = cv;
    bus.issue_valid = 1;
  endtask

  task automatic do_issue(input logic [3:0] op, input logic [3:0] dest,
                          input logic bp, input logic [2:0] bt, input logic [15:0] bv,
                          input logic cp, input logic [2:0] ct, input logic [15:0] cv);
    set_issue(op, dest, bp, bt, bv, cp, ct, cv);
    tick();
    bus.issue_valid = 0; bus.issue_b_pend = 0; bus.issue_c_pend = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 0; tick(); tick();
    n_cmp++; if (bus.issue_ready !== 1'b0) begin n_bad++; $display("FAIL rst_issue_ready_low got=%0h exp=0", bus.issue_ready); end
    n_cmp++; if (bus.occupancy !== 4'd0) begin n_bad++; $display("FAIL rst_occ_low got=%0d exp=0", bus.occupancy); end
    n_cmp++; if (bus.alu_valid !== 1'b0 || bus.mem_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valids_low got=%0b%0b exp=00", bus.alu_valid, bus.mem_valid); end
    resetn = 1; tick();
    n_cmp++; if (bus.issue_ready !== 1'b1) begin n_bad++; $display("FAIL rst_issue_ready got=%0h exp=1", bus.issue_ready); end
    n_cmp++; if (bus.issue_tag !== 3'd0) begin n_bad++; $display("FAIL rst_issue_tag got=%0d exp=0", bus.issue_tag); end
    n_cmp++; if (bus.occupancy !== 4'd0) begin n_bad++; $display("FAIL rst_occ got=%0d exp=0", bus.occupancy); end
    n_cmp++; if (bus.alu_valid !== 1'b0 || bus.mem_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valids got=%0b%0b exp=00", bus.alu_valid, bus.mem_valid); end
  endtask

  task automatic test_basic();
    do_reset();
    do_issue(4'h0, 4'd2, 0, 3'd0, 16'd5, 0, 3'd0, 16'd7);
    n_cmp++; if (bus.alu_valid !== 1'b1 || bus.mem_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valids got=%0b%0b exp=10", bus.alu_valid, bus.mem_valid); end
    n_cmp++; if (bus.out_tag !== 3'd0) begin n_bad++; $display("FAIL basic_tag got=%0d exp=0", bus.out_tag); end
    n_cmp++; if (bus.out_b !== 16'd5 || bus.out_c !== 16'd7) begin n_bad++; $display("FAIL basic_operands got=%0h/%0h exp=5/7", bus.out_b, bus.out_c); end
    n_cmp++; if (bus.out_dest !== 4'd2) begin n_bad++; $display("FAIL basic_dest got=%0d exp=2", bus.out_dest); end
    n_cmp++; if (bus.occupancy !== 4'd1 || bus.issue_tag !== 3'd1) begin n_bad++; $display("FAIL basic_occ_tag got=%0d/%0d exp=1/1", bus.occupancy, bus.issue_tag); end
    // CDB naming a READY (not RUNNING) entry frees nothing
    bus.cdb_valid = 1; bus.cdb_tag = 3'd0; bus.cdb_data = 16'h1111; tick(); bus.cdb_valid = 0;
    n_cmp++; if (bus.occupancy !== 4'd1 || bus.alu_valid !== 1'b1) begin n_bad++; $display("FAIL basic_cdb_nonrunning got=occ%0d/v%0b exp=occ1/v1", bus.occupancy, bus.alu_valid); end
    bus.alu_ready = 1; tick(); bus.alu_ready = 0;
    n_cmp++; if (bus.alu_valid !== 1'b0 || bus.occupancy !== 4'd1) begin n_bad++; $display("FAIL basic_running got=v%0b/occ%0d exp=v0/occ1", bus.alu_valid, bus.occupancy); end
    bus.cdb_valid = 1; bus.cdb_tag = 3'd0; bus.cdb_data = 16'h1234; tick(); bus.cdb_valid = 0;
    n_cmp++; if (bus.occupancy !== 4'd0 || bus.issue_tag !== 3'd0) begin n_bad++; $display("FAIL basic_freed got=occ%0d/tag%0d exp=occ0/tag0", bus.occupancy, bus.issue_tag); end
  endtask

  task automatic test_cdb_wakeup();
    do_reset();
    do_issue(4'h1, 4'd3, 0, 3'd0, 16'd1, 0, 3'd0, 16'd2);
    do_issue(4'h1, 4'd4, 1, 3'd0, 16'd0, 0, 3'd0, 16'd3);
    n_cmp++; if (bus.out_tag !== 3'd0 || bus.alu_valid !== 1'b1) begin n_bad++; $display("FAIL wake_first got=tag%0d/v%0b exp=tag0/v1", bus.out_tag, bus.alu_valid); end
    bus.alu_ready = 1; tick(); bus.alu_ready = 0;
    n_cmp++; if (bus.alu_valid !== 1'b0) begin n_bad++; $display("FAIL wake_waiting got=%0b exp=0", bus.alu_valid); end
    bus.cdb_valid = 1; bus.cdb_tag = 3'd0; bus.cdb_data = 16'h0033; tick(); bus.cdb_valid = 0;
    n_cmp++; if (bus.alu_valid !== 1'b1 || bus.out_tag !== 3'd1) begin n_bad++; $display("FAIL wake_ready got=v%0b/tag%0d exp=v1/tag1", bus.alu_valid, bus.out_tag); end
    n_cmp++; if (bus.out_b !== 16'h0033 || bus.out_c !== 16'd3) begin n_bad++; $display("FAIL wake_operands got=%0h/%0h exp=33/3", bus.out_b, bus.out_c); end
    n_cmp++; if (bus.occupancy !== 4'd1 || bus.issue_tag !== 3'd0) begin n_bad++; $display("FAIL wake_tag0_freed got=occ%0d/tag%0d exp=occ1/tag0", bus.occupancy, bus.issue_tag); end
  endtask

  task automatic test_full();
    do_reset();
    do_issue(4'h1, 4'd1, 0, 3'd0, 16'd1, 0, 3'd0, 16'd2);
    bus.alu_ready = 1; tick(); bus.alu_ready = 0;   // tag0 now RUNNING
    for (int k = 1; k < 8; k++) begin
      n_cmp++; if (bus.issue_tag !== 3'(k)) begin n_bad++; $display("FAIL full_alloc_order got=%0d exp=%0d", bus.issue_tag, k); end
      do_issue(4'h2, 4'(k), 1, 3'd7, 16'd0, 0, 3'd0, 16'd0);
    end
    n_cmp++; if (bus.occupancy !== 4'd8 || bus.issue_ready !== 1'b0) begin n_bad++; $display("FAIL full_state got=occ%0d/rdy%0b exp=occ8/rdy0", bus.occupancy, bus.issue_ready); end
    n_cmp++; if (bus.alu_valid !== 1'b0 || bus.mem_valid !== 1'b0) begin n_bad++; $display("FAIL full_no_dispatch got=%0b%0b exp=00", bus.alu_valid, bus.mem_valid); end
    set_issue(4'h3, 4'd9, 0, 3'd0, 16'h000A, 0, 3'd0, 16'h000B);
    bus.cdb_valid = 1; bus.cdb_tag = 3'd0; bus.cdb_data = 16'h0099; tick(); bus.cdb_valid = 0;
    n_cmp++; if (bus.occupancy !== 4'd7 || bus.issue_ready !== 1'b1 || bus.issue_tag !== 3'd0) begin n_bad++; $display("FAIL full_free_no_admit got=occ%0d/rdy%0b/tag%0d exp=occ7/rdy1/tag0", bus.occupancy, bus.issue_ready, bus.issue_tag); end
    tick(); bus.issue_valid = 0;
    n_cmp++; if (bus.occupancy !== 4'd8 || bus.issue_ready !== 1'b0) begin n_bad++; $display("FAIL full_admitted got=occ%0d/rdy%0b exp=occ8/rdy0", bus.occupancy, bus.issue_ready); end
    n_cmp++; if (bus.alu_valid !== 1'b1 || bus.out_tag !== 3'd0 || bus.out_b !== 16'h000A) begin n_bad++; $display("FAIL full_new_op got=v%0b/tag%0d/b%0h exp=v1/tag0/bA", bus.alu_valid, bus.out_tag, bus.out_b); end
  endtask

  task automatic test_bypass();
    do_reset();
    set_issue(4'h1, 4'd5, 1, 3'd3, 16'd0, 0, 3'd0, 16'h0011);
    bus.cdb_valid = 1; bus.cdb_tag = 3'd3; bus.cdb_data = 16'h00AA;
    tick();
    bus.cdb_valid = 0; bus.issue_valid = 0; bus.issue_b_pend = 0;
    n_cmp++; if (bus.alu_valid !== 1'b1 || bus.out_tag !== 3'd0) begin n_bad++; $display("FAIL bypass_ready got=v%0b/tag%0d exp=v1/tag0", bus.alu_valid, bus.out_tag); end
    n_cmp++; if (bus.out_b !== 16'h00AA || bus.out_c !== 16'h0011) begin n_bad++; $display("FAIL bypass_operands got=%0h/%0h exp=aa/11", bus.out_b, bus.out_c); end
    n_cmp++; if (bus.occupancy !== 4'd1) begin n_bad++; $display("FAIL bypass_occ got=%0d exp=1", bus.occupancy); end
  endtask

  task automatic test_mem_hol();
    do_reset();
    do_issue(4'h1, 4'd0, 1, 3'd7, 16'd0, 0, 3'd0, 16'd0);
    do_issue(4'h1, 4'd1, 1, 3'd7, 16'd0, 0, 3'd0, 16'd0);
    do_issue(4'h8, 4'd2, 0, 3'd0, 16'h0022, 0, 3'd0, 16'h0044);   // tag2: memory op
    do_issue(4'h1, 4'd3, 1, 3'd7, 16'd0, 0, 3'd0, 16'd0);
    do_issue(4'h1, 4'd4, 1, 3'd7, 16'd0, 0, 3'd0, 16'd0);
    do_issue(4'h2, 4'd5, 0, 3'd0, 16'h0055, 0, 3'd0, 16'h0066);   // tag5: ALU op
    n_cmp++; if (bus.mem_valid !== 1'b1 || bus.alu_valid !== 1'b0 || bus.out_tag !== 3'd2) begin n_bad++; $display("FAIL hol_select got=m%0b/a%0b/tag%0d exp=m1/a0/tag2", bus.mem_valid, bus.alu_valid, bus.out_tag); end
    n_cmp++; if (bus.out_op !== 4'h8 || bus.out_b !== 16'h0022) begin n_bad++; $display("FAIL hol_bundle got=op%0h/b%0h exp=op8/b22", bus.out_op, bus.out_b); end
    bus.alu_ready = 1; tick();
    n_cmp++; if (bus.mem_valid !== 1'b1 || bus.alu_valid !== 1'b0 || bus.out_tag !== 3'd2) begin n_bad++; $display("FAIL hol_blocked got=m%0b/a%0b/tag%0d exp=m1/a0/tag2", bus.mem_valid, bus.alu_valid, bus.out_tag); end
    bus.mem_ready = 1; tick(); bus.mem_ready = 0;
    n_cmp++; if (bus.alu_valid !== 1'b1 || bus.mem_valid !== 1'b0 || bus.out_tag !== 3'd5) begin n_bad++; $display("FAIL hol_next got=a%0b/m%0b/tag%0d exp=a1/m0/tag5", bus.alu_valid, bus.mem_valid, bus.out_tag); end
    n_cmp++; if (bus.out_b !== 16'h0055 || bus.out_c !== 16'h0066) begin n_bad++; $display("FAIL hol_next_operands got=%0h/%0h exp=55/66", bus.out_b, bus.out_c); end
    tick(); bus.alu_ready = 0;
    n_cmp++; if (bus.alu_valid !== 1'b0 || bus.mem_valid !== 1'b0 || bus.occupancy !== 4'd6) begin n_bad++; $display("FAIL hol_drained got=a%0b/m%0b/occ%0d exp=a0/m0/occ6", bus.alu_valid, bus.mem_valid, bus.occupancy); end
  endtask

  // Leaves tags 0..3 RUNNING for test_flush.
  task automatic test_back_to_back();
    do_reset();
    bus.alu_ready = 1;
    for (int k = 0; k < 4; k++) begin
      do_issue(4'h1, 4'(k), 0, 3'd0, 16'(k + 16), 0, 3'd0, 16'd0);
      n_cmp++; if (bus.alu_valid !== 1'b1 || bus.out_tag !== 3'(k) || bus.out_b !== 16'(k + 16)) begin n_bad++; $display("FAIL b2b_dispatch got=v%0b/tag%0d/b%0h exp=v1/tag%0d/b%0h", bus.alu_valid, bus.out_tag, bus.out_b, k, k + 16); end
    end
    tick(); bus.alu_ready = 0;
    n_cmp++; if (bus.alu_valid !== 1'b0 || bus.occupancy !== 4'd4) begin n_bad++; $display("FAIL b2b_all_running got=v%0b/occ%0d exp=v0/occ4", bus.alu_valid, bus.occupancy); end
  endtask

  task automatic test_flush();
    set_issue(4'h1, 4'd7, 0, 3'd0, 16'd1, 0, 3'd0, 16'd1);
    flush = 1; tick(); flush = 0; bus.issue_valid = 0;
    n_cmp++; if (bus.occupancy !== 4'd0) begin n_bad++; $display("FAIL flush_occ got=%0d exp=0", bus.occupancy); end
    n_cmp++; if (bus.alu_valid !== 1'b0 || bus.mem_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valids got=%0b%0b exp=00", bus.alu_valid, bus.mem_valid); end
    n_cmp++; if (bus.issue_ready !== 1'b1 || bus.issue_tag !== 3'd0) begin n_bad++; $display("FAIL flush_issue got=rdy%0b/tag%0d exp=rdy1/tag0", bus.issue_ready, bus.issue_tag); end
    tick();
    n_cmp++; if (bus.occupancy !== 4'd0 || bus.alu_valid !== 1'b0) begin n_bad++; $display("FAIL flush_no_entry got=occ%0d/v%0b exp=occ0/v0", bus.occupancy, bus.alu_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cdb_wakeup();
    test_full();
    test_bypass();
    test_mem_hol();
    test_back_to_back();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
